// File: rtl/fifo_queue_if.sv
// Producer/consumer bundle for fifo_queue: push/din in, pop/dout/dout_valid out, plus status.
interface fifo_queue_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
);
    // push/pop are requests, not handshakes. A request is taken at posedge only if the
    // queue can honour it (push needs ~full, pop needs ~empty). Rejected requests have no
    // effect other than the optional error flags. dout_valid pulses one cycle after a taken pop.
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             full;
    logic             empty;
    logic [AW:0]      count;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, din,
        input  dout, dout_valid, full, empty, count, overflow, underflow
    );

    modport slave (
        input  push, pop, din,
        output dout, dout_valid, full, empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_queue.sv
// Synchronous FIFO, 2**AW x WIDTH, registered read data with a 1-cycle valid pulse.
// Optional sticky overflow/underflow flags are built when FIFO_ERR_FLAGS_EN is defined.
module fifo_queue #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input logic          clk,
    input logic          rst,
    fifo_queue_if.slave  bus
);
    localparam int          DEPTH  = 1 << AW;
    localparam logic [AW:0] C_FULL = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;

    logic w_full;
    logic w_empty;
    logic w_push_ok;
    logic w_pop_ok;

    assign w_full    = (r_count == C_FULL);
    assign w_empty   = (r_count == '0);
    assign w_push_ok = bus.push & ~w_full;
    assign w_pop_ok  = bus.pop & ~w_empty;

    // Storage carries no reset; stale words are unreachable once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= bus.din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_dout   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_dout_valid <= w_pop_ok;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.push && w_full) begin
                r_overflow <= 1'b1;
            end
            if (bus.pop && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.full       = w_full;
    assign bus.empty      = w_empty;
    assign bus.count      = r_count;
endmodule
